adc_frame_writer: RTL and testbench



---
 rtl/adc_wr_pkg.sv | 16 +
 rtl/adc_frame_writer_if.sv | 22 ++
 rtl/adc_wr_addr_ring.sv | 44 ++++
 rtl/adc_frame_writer.sv | 154 +++++++++++++++
 tb/tb_adc_frame_writer.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/adc_wr_pkg.sv
// Shared types and defaults for the ADC frame writer (FSM states, ring geometry, FIFO level width).
package adc_wr_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWaitData,
    StBurst,
    StNext
  } adc_wr_state_e;

  localparam int unsigned DefBurstLen   = 128;
  localparam int unsigned DefBaseAddr   = 0;
  localparam int unsigned DefRegionWords = 1048576;
  localparam int unsigned RdusedwBits   = 11;

endpackage

// File: rtl/adc_frame_writer_if.sv
// Write-burst bus between the frame writer (master) and the DDR3 burst controller (slave).
interface adc_frame_writer_if #(
  parameter int unsigned MEM_DATA_BITS = 64,
  parameter int unsigned ADDR_BITS     = 24
);
  logic                     wr_burst_req;
  logic [9:0]               wr_burst_len;
  logic [ADDR_BITS-1:0]     wr_burst_addr;
  logic                     wr_burst_data_req;
  logic [MEM_DATA_BITS-1:0] wr_burst_data;
  logic                     wr_burst_finish;

  modport master (
    output wr_burst_req, wr_burst_len, wr_burst_addr, wr_burst_data,
    input  wr_burst_data_req, wr_burst_finish
  );

  modport slave (
    input  wr_burst_req, wr_burst_len, wr_burst_addr, wr_burst_data,
    output wr_burst_data_req, wr_burst_finish
  );
endinterface

// File: rtl/adc_wr_addr_ring.sv
// Circular burst address register; remembers the start address of the burst just completed.
module adc_wr_addr_ring #(
  parameter int unsigned ADDR_BITS    = 24,
  parameter int unsigned BURST_LEN    = 128,
  parameter int unsigned BASE_ADDR    = 0,
  parameter int unsigned REGION_WORDS = 1048576
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 advance_i,
  output logic [ADDR_BITS-1:0] addr_o,
  output logic [ADDR_BITS-1:0] last_addr_o
);
  localparam int unsigned SumBits = ADDR_BITS + 1;
  localparam logic [ADDR_BITS-1:0] BaseAddr = ADDR_BITS'(BASE_ADDR);
  localparam logic [ADDR_BITS:0]   EndAddr  = SumBits'(BASE_ADDR + REGION_WORDS);

  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [ADDR_BITS-1:0] last_q;
  logic [ADDR_BITS:0]   sum;

  // One extra bit so the wrap compare sees the untruncated sum.
  assign sum = {1'b0, addr_q} + SumBits'(BURST_LEN);

  always_comb begin
    addr_d = addr_q;
    if (advance_i) begin
      addr_d = (sum >= EndAddr) ? BaseAddr : sum[ADDR_BITS-1:0];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q <= BaseAddr;
      last_q <= BaseAddr;
    end else begin
      addr_q <= addr_d;
      if (advance_i) last_q <= addr_q;
    end
  end

  assign addr_o      = addr_q;
  assign last_addr_o = last_q;
endmodule

// File: rtl/adc_frame_writer.sv
// Drains the FWFT sample FIFO into fixed-length DDR3 write bursts around a circular region.
// Optional FIFO-full cycle counter enabled by defining ADC_WR_OVF_CNT_EN.
module adc_frame_writer
  import adc_wr_pkg::*;
#(
  parameter int unsigned MEM_DATA_BITS = 64,
  parameter int unsigned ADDR_BITS     = 24,
  parameter int unsigned BURST_LEN     = DefBurstLen,
  parameter int unsigned BASE_ADDR     = DefBaseAddr,
  parameter int unsigned REGION_WORDS  = DefRegionWords
) (
  input  logic                     mem_clk,
  input  logic                     rst,
  input  logic                     calib_done,
  input  logic                     capture_start,
  input  logic                     capture_stop,
  input  logic [15:0]              capture_bursts,
  output logic                     busy,
  output logic                     done,
  output logic [ADDR_BITS-1:0]     last_addr,
  output logic [15:0]              bursts_done,
  output logic                     fifo_rd_en,
  input  logic [MEM_DATA_BITS-1:0] fifo_dout,
  input  logic [RdusedwBits-1:0]   fifo_rdusedw,
  input  logic                     fifo_full,
  adc_frame_writer_if.master       wr,
  output logic [15:0]              ovf_cnt
);
  localparam logic [RdusedwBits-1:0] BurstLevel = RdusedwBits'(BURST_LEN);

  adc_wr_state_e state_q, state_d;
  logic          busy_q, busy_d, done_q, done_d, req_q, req_d, abort_q, abort_d;
  logic [15:0]   count_q, count_d, bursts_done_q, bursts_done_d, bursts_inc;
  logic          advance;

  assign bursts_inc = bursts_done_q + 16'd1;

  always_comb begin
    state_d       = state_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    req_d         = req_q;
    abort_d       = abort_q;
    count_d       = count_q;
    bursts_done_d = bursts_done_q;
    advance       = 1'b0;
    if (busy_q && capture_stop) abort_d = 1'b1;
    case (state_q)
      StIdle: begin
        if (capture_start && calib_done) begin
          if (capture_bursts != 16'd0) begin
            count_d       = capture_bursts;
            bursts_done_d = 16'd0;
            abort_d       = 1'b0;
            busy_d        = 1'b1;
            state_d       = StWaitData;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StWaitData: begin
        // A stop here leaves any partial FIFO contents untouched.
        if (abort_q || capture_stop) begin
          state_d = StIdle;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (fifo_rdusedw >= BurstLevel) begin
          req_d   = 1'b1;
          state_d = StBurst;
        end
      end
      StBurst: begin
        if (wr.wr_burst_finish) begin
          req_d   = 1'b0;
          state_d = StNext;
        end
      end
      StNext: begin
        advance       = 1'b1;
        bursts_done_d = bursts_inc;
        if (bursts_inc == count_q || abort_q || capture_stop) begin
          state_d = StIdle;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = StWaitData;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge mem_clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      req_q         <= 1'b0;
      abort_q       <= 1'b0;
      count_q       <= 16'd0;
      bursts_done_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      req_q         <= req_d;
      abort_q       <= abort_d;
      count_q       <= count_d;
      bursts_done_q <= bursts_done_d;
    end
  end

  adc_wr_addr_ring #(
    .ADDR_BITS    (ADDR_BITS),
    .BURST_LEN    (BURST_LEN),
    .BASE_ADDR    (BASE_ADDR),
    .REGION_WORDS (REGION_WORDS)
  ) u_addr_ring (
    .clk_i       (mem_clk),
    .rst_i       (rst),
    .advance_i   (advance),
    .addr_o      (wr.wr_burst_addr),
    .last_addr_o (last_addr)
  );

  assign busy             = busy_q;
  assign done             = done_q;
  assign bursts_done      = bursts_done_q;
  assign wr.wr_burst_req  = req_q;
  assign wr.wr_burst_len  = 10'(BURST_LEN);
  assign wr.wr_burst_data = fifo_dout;
  assign fifo_rd_en       = (state_q == StBurst) && wr.wr_burst_data_req;

`ifdef ADC_WR_OVF_CNT_EN
  logic [15:0] ovf_q;

  always_ff @(posedge mem_clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 16'd0;
    end else if (state_q == StIdle && capture_start) begin
      ovf_q <= 16'd0;
    end else if (busy_q && fifo_full && ovf_q != 16'hFFFF) begin
      ovf_q <= ovf_q + 16'd1;
    end
  end

  assign ovf_cnt = ovf_q;
`else
  logic unused_fifo_full;
  assign unused_fifo_full = fifo_full;
  assign ovf_cnt          = 16'd0;
`endif
endmodule

// File: tb/tb_adc_frame_writer.sv
// Directed bench for adc_frame_writer: FIFO and burst-controller models around a 512-word ring.
module tb_adc_frame_writer;
  localparam int unsigned BL = 128;
  localparam int unsigned RW = 512;
  localparam int unsigned DW = 64;
  localparam int unsigned AW = 24;

  logic          mem_clk = 1'b0;
  logic          rst, calib_done, capture_start, capture_stop, fifo_full;
  logic [15:0]   capture_bursts;
  logic          busy, done, fifo_rd_en;
  logic [AW-1:0] last_addr;
  logic [15:0]   bursts_done, ovf_cnt;
  logic [DW-1:0] fifo_dout;
  logic [10:0]   fifo_rdusedw;

  adc_frame_writer_if #(.MEM_DATA_BITS(DW), .ADDR_BITS(AW)) wr_bus ();

  adc_frame_writer #(
    .MEM_DATA_BITS (DW),
    .ADDR_BITS     (AW),
    .BURST_LEN     (BL),
    .BASE_ADDR     (0),
    .REGION_WORDS  (RW)
  ) dut (
    .mem_clk        (mem_clk),
    .rst            (rst),
    .calib_done     (calib_done),
    .capture_start  (capture_start),
    .capture_stop   (capture_stop),
    .capture_bursts (capture_bursts),
    .busy           (busy),
    .done           (done),
    .last_addr      (last_addr),
    .bursts_done    (bursts_done),
    .fifo_rd_en     (fifo_rd_en),
    .fifo_dout      (fifo_dout),
    .fifo_rdusedw   (fifo_rdusedw),
    .fifo_full      (fifo_full),
    .wr             (wr_bus.master),
    .ovf_cnt        (ovf_cnt)
  );

  always #5 mem_clk = ~mem_clk;

  int vectors = 0, miscompares = 0;
  int wr_total = 0, rd_total = 0, exp_rd = 0, data_err = 0;
  int done_cnt = 0, busy_cnt = 0;
  logic [AW-1:0] burst_addrs[$];

  function automatic logic [63:0] pat(int n);
    return 64'hA5A5_0000_0000_0000 | 64'(n);
  endfunction

  assign fifo_dout    = pat(rd_total);
  assign fifo_rdusedw = 11'(wr_total - rd_total);

  always @(posedge mem_clk) begin
    if (fifo_rd_en) rd_total <= rd_total + 1;
    if (done)       done_cnt <= done_cnt + 1;
    if (busy)       busy_cnt <= busy_cnt + 1;
  end

  // Burst controller model: streams BL words per request, then a finish pulse.
  initial begin
    wr_bus.wr_burst_data_req = 1'b0;
    wr_bus.wr_burst_finish   = 1'b0;
    forever begin
      @(negedge mem_clk);
      if (wr_bus.wr_burst_req && !rst) begin
        burst_addrs.push_back(wr_bus.wr_burst_addr);
        for (int i = 0; i < int'(BL) && !rst; i++) begin
          wr_bus.wr_burst_data_req = 1'b1;
          if (wr_bus.wr_burst_data !== pat(exp_rd)) data_err++;
          exp_rd++;
          @(negedge mem_clk);
        end
        wr_bus.wr_burst_data_req = 1'b0;
        if (!rst) begin
          wr_bus.wr_burst_finish = 1'b1;
          @(negedge mem_clk);
          wr_bus.wr_burst_finish = 1'b0;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge mem_clk);
  endtask

  task automatic start_capture(input int n);
    @(negedge mem_clk);
    capture_bursts = 16'(n);
    capture_start  = 1'b1;
    @(negedge mem_clk);
    capture_start  = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    for (int i = 0; i < limit && !done; i++) @(negedge mem_clk);
    if (!done) check("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_req(input int limit);
    for (int i = 0; i < limit && !wr_bus.wr_burst_req; i++) @(negedge mem_clk);
    if (!wr_bus.wr_burst_req) check("req_timeout", 64'd0, 64'd1);
  endtask

  int r0, d0, b0;
  logic [63:0] exp_ovf;

  initial begin
    rst = 1'b1; calib_done = 1'b0; capture_start = 1'b0; capture_stop = 1'b0;
    capture_bursts = 16'd0; fifo_full = 1'b0;
    cycles(3);
    rst = 1'b0;
    cycles(1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_req", 64'(wr_bus.wr_burst_req), 64'd0);
    check("rst_rd_en", 64'(fifo_rd_en), 64'd0);
    check("rst_addr", 64'(wr_bus.wr_burst_addr), 64'd0);
    check("rst_last_addr", 64'(last_addr), 64'd0);
    check("rst_bursts_done", 64'(bursts_done), 64'd0);
    check("rst_ovf", 64'(ovf_cnt), 64'd0);
    check("burst_len", 64'(wr_bus.wr_burst_len), 64'(BL));

    // Start without calibration is ignored
    d0 = done_cnt; b0 = busy_cnt;
    start_capture(3);
    cycles(4);
    check("nocal_busy", 64'(busy_cnt - b0), 64'd0);
    check("nocal_done", 64'(done_cnt - d0), 64'd0);
    calib_done = 1'b1;

    // Zero-burst start: done next cycle, busy never set
    d0 = done_cnt; b0 = busy_cnt;
    start_capture(0);
    check("zero_done_pulse", 64'(done), 64'd1);
    cycles(3);
    check("zero_done_once", 64'(done_cnt - d0), 64'd1);
    check("zero_busy", 64'(busy_cnt - b0), 64'd0);

    // Normal capture of 3 bursts
    wr_total += 512;
    burst_addrs.delete(); r0 = rd_total; d0 = done_cnt;
    start_capture(3);
    check("norm_req_1cyc", 64'(wr_bus.wr_burst_req), 64'd0);
    @(negedge mem_clk);
    check("norm_req_2cyc", 64'(wr_bus.wr_burst_req), 64'd1);
    wait_done(2000);
    cycles(2);
    check("norm_nbursts", 64'(burst_addrs.size()), 64'd3);
    check("norm_addr0", 64'(burst_addrs[0]), 64'd0);
    check("norm_addr1", 64'(burst_addrs[1]), 64'd128);
    check("norm_addr2", 64'(burst_addrs[2]), 64'd256);
    check("norm_rd_en", 64'(rd_total - r0), 64'd384);
    check("norm_done", 64'(done_cnt - d0), 64'd1);
    check("norm_last_addr", 64'(last_addr), 64'd256);
    check("norm_bursts_done", 64'(bursts_done), 64'd3);
    check("norm_busy", 64'(busy), 64'd0);

    // Ring wrap at 512 words
    wr_total += 256;
    burst_addrs.delete();
    start_capture(3);
    wait_done(2000);
    cycles(2);
    check("wrap_nbursts", 64'(burst_addrs.size()), 64'd3);
    check("wrap_addr0", 64'(burst_addrs[0]), 64'd384);
    check("wrap_addr1", 64'(burst_addrs[1]), 64'd0);
    check("wrap_addr2", 64'(burst_addrs[2]), 64'd128);
    check("wrap_last_addr", 64'(last_addr), 64'd128);

    // Starvation: no request until 128 words are available
    wr_total += 100;
    burst_addrs.delete(); r0 = rd_total;
    start_capture(1);
    cycles(50);
    check("starve_req", 64'(wr_bus.wr_burst_req), 64'd0);
    check("starve_nbursts0", 64'(burst_addrs.size()), 64'd0);
    wr_total += 28;
    wait_done(1000);
    cycles(2);
    check("starve_nbursts", 64'(burst_addrs.size()), 64'd1);
    check("starve_addr", 64'(burst_addrs[0]), 64'd256);
    check("starve_rd_en", 64'(rd_total - r0), 64'd128);

    // Abort during the first of four bursts
    wr_total += 512;
    burst_addrs.delete(); r0 = rd_total; d0 = done_cnt;
    start_capture(4);
    wait_req(100);
    cycles(10);
    capture_stop = 1'b1;
    @(negedge mem_clk);
    capture_stop = 1'b0;
    wait_done(1000);
    cycles(20);
    check("abort_nbursts", 64'(burst_addrs.size()), 64'd1);
    check("abort_addr", 64'(burst_addrs[0]), 64'd384);
    check("abort_rd_en", 64'(rd_total - r0), 64'd128);
    check("abort_bursts_done", 64'(bursts_done), 64'd1);
    check("abort_done", 64'(done_cnt - d0), 64'd1);
    check("abort_req", 64'(wr_bus.wr_burst_req), 64'd0);

    // FIFO-full counting over 10 busy cycles
    start_capture(1);
    wait_req(100);
    fifo_full = 1'b1;
    cycles(10);
    fifo_full = 1'b0;
    wait_done(1000);
    cycles(2);
`ifdef ADC_WR_OVF_CNT_EN
    exp_ovf = 64'd10;
`else
    exp_ovf = 64'd0;
`endif
    check("ovf_cnt", 64'(ovf_cnt), exp_ovf);
    check("ovf_last_addr", 64'(last_addr), 64'd0);
    check("data_words", 64'(data_err), 64'd0);

    // Asynchronous reset during the second burst
    start_capture(2);
    for (int i = 0; i < 1000 && bursts_done != 16'd1; i++) @(negedge mem_clk);
    check("pre_rst_bursts_done", 64'(bursts_done), 64'd1);
    wait_req(100);
    cycles(20);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_req", 64'(wr_bus.wr_burst_req), 64'd0);
    check("arst_rd_en", 64'(fifo_rd_en), 64'd0);
    check("arst_addr", 64'(wr_bus.wr_burst_addr), 64'd0);
    check("arst_last_addr", 64'(last_addr), 64'd0);
    check("arst_bursts_done", 64'(bursts_done), 64'd0);
    check("arst_ovf", 64'(ovf_cnt), 64'd0);
    cycles(2);
    rst = 1'b0;
    cycles(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
